// File: rtl/gpr_bank.sv
// Parametrised multi-port register bank with per-register busy scoreboard,
// registered reads with write-through bypass, and a hardwired-zero register 0.
module gpr_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WRITE_PORTS-1:0]            write_enable,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] waddr,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wdata,
    input  logic [READ_PORTS-1:0]             read_enable,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  raddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  rdata,
    output logic [READ_PORTS-1:0]             rbusy,
    input  logic                              reserve_enable,
    input  logic [ADDR_WIDTH-1:0]             reserve_addr,
    input  logic                              flush
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_badReadPorts
        $error("gpr_bank: READ_PORTS must be in 1..4");
    end
    if (WRITE_PORTS < 1 || WRITE_PORTS > 2) begin : g_badWritePorts
        $error("gpr_bank: WRITE_PORTS must be in 1..2");
    end
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1) begin : g_badWidths
        $error("gpr_bank: DATA_WIDTH and ADDR_WIDTH must be positive");
    end

    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   r_busy;

    logic [NUM_REGS-1:1]   w_hit;
    logic [DATA_WIDTH-1:0] w_winData [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   w_busyNext;
    logic [DATA_WIDTH-1:0] w_readView [0:NUM_REGS-1];
    logic [NUM_REGS-1:0]   w_busyView;

    // Ascending port scan so the highest-index matching port wins the register.
    always_comb begin
        for (int a = 1; a < NUM_REGS; a++) begin
            w_hit[a]     = 1'b0;
            w_winData[a] = '0;
            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (write_enable[k] && (waddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a))) begin
                    w_hit[a]     = 1'b1;
                    w_winData[a] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // A reserve beats a same-cycle write because it marks a newer producer.
    always_comb begin
        for (int a = 1; a < NUM_REGS; a++) begin
            if (flush)
                w_busyNext[a] = 1'b0;
            else if (reserve_enable && (reserve_addr == ADDR_WIDTH'(a)))
                w_busyNext[a] = 1'b1;
            else if (w_hit[a])
                w_busyNext[a] = 1'b0;
            else
                w_busyNext[a] = r_busy[a];
        end
    end

    always_comb begin
        w_readView[0] = '0;
        for (int a = 1; a < NUM_REGS; a++) begin
            w_readView[a] = w_hit[a] ? w_winData[a] : r_regs[a];
        end
        w_busyView = {w_busyNext, 1'b0};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int a = 1; a < NUM_REGS; a++) begin
                r_regs[a] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int a = 1; a < NUM_REGS; a++) begin
                if (w_hit[a])
                    r_regs[a] <= w_winData[a];
            end
            r_busy <= w_busyNext;
        end
    end

    // Register 0 reads as zero through the view arrays as well as the explicit check.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            rbusy <= '0;
        end else begin
            for (int i = 0; i < READ_PORTS; i++) begin
                if (!read_enable[i] || (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    rbusy[i]                          <= 1'b0;
                end else begin
                    rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_readView[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                    rbusy[i]                          <= w_busyView[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_bank.sv
// Directed scoreboard bench for gpr_bank: expectations are queued as stimulus is
// driven and popped after the clock edge that produces the read data.
module tb_gpr_bank;

    logic        clock;
    logic        reset;
    logic [1:0]  write_enable;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  read_enable;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        reserve_enable;
    logic [4:0]  reserve_addr;
    logic        flush;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        busy;
    } expT;

    expT expQ[$];

    gpr_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .WRITE_PORTS(2)
    ) dut (
        .clock(clock), .reset(reset),
        .write_enable(write_enable), .waddr(waddr), .wdata(wdata),
        .read_enable(read_enable), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr),
        .flush(flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        write_enable   = '0;
        waddr          = '0;
        wdata          = '0;
        read_enable    = '0;
        raddr          = '0;
        reserve_enable = 1'b0;
        reserve_addr   = '0;
        flush          = 1'b0;
    endtask

    task automatic setWrite(input int port, input logic [4:0] a, input logic [31:0] d);
        write_enable[port]    = 1'b1;
        waddr[port*5 +: 5]    = a;
        wdata[port*32 +: 32]  = d;
    endtask

    task automatic setRead(input int port, input logic [4:0] a);
        read_enable[port]  = 1'b1;
        raddr[port*5 +: 5] = a;
    endtask

    task automatic compareNow(input string tag, input logic [31:0] obsD, input logic [31:0] expD);
        checks++;
        assert (obsD === expD) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obsD, expD);
        end
    endtask

    // Queue both ports' expectations, then clock the stimulus in.
    task automatic applyStimulus(input string tag,
                                 input logic [31:0] d0, input logic b0,
                                 input logic [31:0] d1, input logic b1);
        expT e;
        e.tag = {tag, "/p0"}; e.port = 0; e.data = d0; e.busy = b0;
        expQ.push_back(e);
        e.tag = {tag, "/p1"}; e.port = 1; e.data = d1; e.busy = b1;
        expQ.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput();
        expT e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareNow({e.tag, ".rdata"}, rdata[e.port*32 +: 32], e.data);
            compareNow({e.tag, ".rbusy"}, {31'b0, rbusy[e.port]}, {31'b0, e.busy});
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        // Random traffic while held in reset must leave all outputs cleared.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            write_enable   = 2'($urandom);
            waddr          = 10'($urandom);
            wdata          = {$urandom, $urandom};
            read_enable    = 2'b11;
            raddr          = 10'($urandom);
            reserve_enable = 1'($urandom);
            reserve_addr   = 5'($urandom);
            compareNow("reset.rdata", rdata[31:0] | rdata[63:32], 32'h0);
            compareNow("reset.rbusy", {30'b0, rbusy}, 32'h0);
        end
        @(negedge clock);
        idle();
        reset = 1'b1;
        #1;

        for (int r = 0; r < 32; r += 2) begin
            setRead(0, 5'(r));
            setRead(1, 5'(r + 1));
            applyStimulus("postResetRead", 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput();
        end

        setWrite(0, 5'd5, 32'hDEADBEEF);
        applyStimulus("writeR5", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd5);
        raddr[9:5] = 5'd5;
        applyStimulus("readR5.enOff", 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        checkOutput();

        setWrite(0, 5'd0, 32'h1234);
        setRead(1, 5'd0);
        applyStimulus("writeR0", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd0);
        applyStimulus("readR0", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();

        setWrite(0, 5'd7, 32'h11);
        setWrite(1, 5'd7, 32'h22);
        setRead(0, 5'd7);
        applyStimulus("conflictBypass", 32'h22, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(1, 5'd7);
        setRead(0, 5'd5);
        applyStimulus("readR7", 32'hDEADBEEF, 1'b0, 32'h22, 1'b0);
        checkOutput();

        reserve_enable = 1'b1;
        reserve_addr   = 5'd9;
        applyStimulus("reserveR9", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd9);
        applyStimulus("readR9busy", 32'h0, 1'b1, 32'h0, 1'b0);
        checkOutput();
        setWrite(0, 5'd9, 32'h55);
        setRead(0, 5'd9);
        setRead(1, 5'd9);
        applyStimulus("writeR9clear", 32'h55, 1'b0, 32'h55, 1'b0);
        checkOutput();
        reserve_enable = 1'b1;
        reserve_addr   = 5'd9;
        setWrite(1, 5'd9, 32'h66);
        setRead(0, 5'd9);
        applyStimulus("reserveWriteR9", 32'h66, 1'b1, 32'h0, 1'b0);
        checkOutput();

        reserve_enable = 1'b1;
        reserve_addr   = 5'd3;
        applyStimulus("reserveR3", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        reserve_enable = 1'b1;
        reserve_addr   = 5'd4;
        setRead(0, 5'd3);
        setRead(1, 5'd4);
        applyStimulus("reserveR4", 32'h0, 1'b1, 32'h0, 1'b1);
        checkOutput();
        flush          = 1'b1;
        reserve_enable = 1'b1;
        reserve_addr   = 5'd5;
        setWrite(0, 5'd6, 32'hCAFE);
        setRead(0, 5'd3);
        setRead(1, 5'd4);
        applyStimulus("flushR3R4", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd5);
        setRead(1, 5'd6);
        applyStimulus("afterFlush", 32'hDEADBEEF, 1'b0, 32'hCAFE, 1'b0);
        checkOutput();
        setRead(0, 5'd9);
        applyStimulus("flushClearedR9", 32'h66, 1'b0, 32'h0, 1'b0);
        checkOutput();

        setWrite(1, 5'd12, 32'hA5A5);
        reserve_enable = 1'b1;
        reserve_addr   = 5'd12;
        applyStimulus("writeReserveR12", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd12);
        setRead(1, 5'd12);
        applyStimulus("readR12", 32'hA5A5, 1'b1, 32'hA5A5, 1'b1);
        setRead(0, 5'd12);
        setRead(1, 5'd12);
        checkOutput();
        setRead(0, 5'd12);
        setRead(1, 5'd12);
        @(negedge clock);
        reset = 1'b0;
        #1;
        compareNow("asyncReset.rdata0", rdata[31:0], 32'h0);
        compareNow("asyncReset.rdata1", rdata[63:32], 32'h0);
        compareNow("asyncReset.rbusy", {30'b0, rbusy}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        applyStimulus("readR12afterReset", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        setRead(0, 5'd5);
        setRead(1, 5'd7);
        applyStimulus("resetClearedAll", 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised multi-port general-purpose register bank for the CPU decode stage. It replaces the fixed two-read/one-write register file with configurable width, depth, read-port count and write-port count. It adds a per-register busy scoreboard, letting the issue logic detect pending writes, and a flush that drops reservations from squashed instructions. Reads are registered with write-through bypass; register 0 is hardwired zero.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register address bits; NUM_REGS = 2**ADDR_WIDTH
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 2, number of write ports (1..2); higher index has priority
- clock  input  1  sole clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- write_enable  input  WRITE_PORTS  per-port write strobe
- waddr  input  WRITE_PORTS*ADDR_WIDTH  write addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- wdata  input  WRITE_PORTS*DATA_WIDTH  write data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
- read_enable  input  READ_PORTS  per-port read strobe
- raddr  input  READ_PORTS*ADDR_WIDTH  read addresses, packed as waddr
- rdata  output  READ_PORTS*DATA_WIDTH  registered read data, packed as wdata
- rbusy  output  READ_PORTS  registered busy flag of the addressed register
- reserve_enable  input  1  mark reserve_addr busy (an instruction was issued that will write it)
- reserve_addr  input  ADDR_WIDTH  register to reserve
- flush  input  1  clear all busy bits

## Operation
- State:
  - regs[1..NUM_REGS-1], DATA_WIDTH each
  - busy[1..NUM_REGS-1], 1 bit each
  - registered rdata and rbusy per read port
  - regs[0] and busy[0] are not stored and always read as 0
- Write resolution, per edge:
  - For each address A != 0, the winning write is the highest-index port k with write_enable[k]=1 and waddr_k=A.
  - If there is a winner, regs[A] <= wdata_k; otherwise regs[A] holds.
  - Writes to address 0 are ignored.
- Busy next-state, per address A != 0, by priority:
  1. flush=1 -> 0
  2. reserve_enable=1 and reserve_addr=A -> 1
  3. any write_enable[k] with waddr_k=A -> 0
  4. otherwise hold
- Busy rules:
  - A reserve together with a write to the same register means a new producer was issued, so busy stays set.
  - A flush overrides a same-cycle reserve; the write data is still committed.
- Read, per port i:
  - If reset is asserted, rdata_i=0 and rbusy_i=0.
  - If read_enable[i]=0 or raddr_i=0, rdata_i <= 0 and rbusy_i <= 0.
  - Otherwise, if a write targets raddr_i this edge, rdata_i <= the winning wdata (bypass).
  - Otherwise rdata_i <= regs[raddr_i].
  - Whenever read_enable[i]=1 and raddr_i != 0, rbusy_i <= busy_next[raddr_i], the post-update value from the rules above.
- Read ports are independent; any number of them may address the same register.
- Reset:
  - While reset=0, asynchronously clear every regs entry, every busy bit, rdata and rbusy to 0.
  - Reset mid-operation discards all pending reservations and writes.
- Out-of-range parameters are rejected at elaboration.

## Timing
- Read latency is 1 cycle: raddr and read_enable sampled at edge N produce rdata/rbusy valid after edge N, held until edge N+1.
- Write latency is 1 cycle to the array, but bypass makes a same-edge read return the new value. There is no combinational path from inputs to outputs.
- The scoreboard is updated at the same edge as the write; rbusy reflects it immediately through busy_next.
- Reservations have no handshake; the issue logic must not reserve a register that is already busy unless it owns that reservation.
- After reset deassertion, the bank accepts reads and writes on the first edge.

## Test plan
- Reset: hold reset=0 with random inputs → all rdata=0, rbusy=0. Release, read all 32 registers → every read is 0.
- Write then read: write 0xDEADBEEF to r5 via port 0, read r5 next cycle → 0xDEADBEEF. Write 0x1234 to r0, read r0 → 0.
- Same-edge bypass and conflict:
  - Port 0 writes r7=0x11 while port 1 writes r7=0x22, and port 0 reads r7 on the same edge → rdata=0x22.
  - A later read of r7 → 0x22.
- Scoreboard:
  - Reserve r9 → next read of r9 gives rbusy=1.
  - Write r9=0x55 → same-edge read gives rdata=0x55, rbusy=0.
  - Reserve r9 and write r9=0x66 on one edge → rbusy=1, rdata=0x66.
- Flush: reserve r3 and r4, then assert flush together with a reserve of r5 → reads of r3, r4 and r5 all show rbusy=0.
- Async reset mid-stream: write r12=0xA5A5 and reserve r12, then pulse reset low between clock edges → outputs clear immediately; a later read of r12 gives 0 with rbusy=0.
